// File: rtl/div_nonrestoring_seq_pkg.sv
// Shared definitions for the sequential non-restoring divider.
//   state_t       : control FSM states (IDLE, ITER, CORRECT, DONE)
//   cnt_width()   : width of the iteration counter for a given operand width
//   DBZ_Q_FILL    : fill bit of the divide-by-zero quotient (all ones)
package div_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ITER    = 2'd1,
    CORRECT = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Counter counts WIDTH-1 down to 0, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  // Divide-by-zero quotient is every bit set to this value.
  localparam logic DBZ_Q_FILL = 1'b1;

endpackage

// File: rtl/div_nonrestoring_seq_cu.sv
// Control unit for the non-restoring divider: owns the state and the
// iteration counter and issues datapath strobes.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : operation request, honoured only in IDLE
//   zero_div  : divisor of the request is zero
//   load      : capture operands this edge (IDLE and start)
//   iterate   : perform one quotient-bit iteration this edge
//   correct   : perform the final remainder correction this edge
//   done      : registered single-cycle result pulse
//   busy      : registered, high from accept until leaving DONE
//   state     : current FSM state (debug visibility)
//
// Handshake: a request is accepted on a rising edge where state is IDLE and
// start is high; start at any other time is ignored. done is high for exactly
// one cycle and busy drops on the edge that leaves DONE.
module div_nonrestoring_seq_cu
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   zero_div,
  output logic   load,
  output logic   iterate,
  output logic   correct,
  output logic   done,
  output logic   busy,
  output state_t state
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] cnt;

  assign load    = (state == IDLE) && start;
  assign iterate = (state == ITER);
  assign correct = (state == CORRECT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (zero_div) begin
              // No iterations: results are written on the accepting edge.
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ITER;
              cnt   <= CW'(WIDTH - 1);
            end
          end
        end
        ITER: begin
          if (cnt == '0) state <= CORRECT;
          else           cnt   <= cnt - 1'b1;
        end
        CORRECT: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/div_nonrestoring_seq.sv
// Sequential non-restoring divider, one quotient bit per clock, unsigned or
// two's-complement per operation, with divide-by-zero flag.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : request (sampled in IDLE only)
//   is_signed    : 1 = two's-complement operands, 0 = unsigned
//   dividend     : numerator, captured with start
//   divisor      : denominator, captured with start
//   busy         : high from accept until the edge leaving DONE
//   done         : single-cycle pulse, results valid
//   quotient     : result, held until the next accepted start
//   remainder    : result (sign follows dividend), held likewise
//   div_by_zero  : divisor was zero, held with the results
module div_nonrestoring_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic   load, iterate, correct;
  state_t state;
  logic   zero_div;

  // Datapath registers; a_r bit WIDTH is the sign of the partial remainder.
  logic [WIDTH:0]   a_r;
  logic [WIDTH-1:0] q_r, m_r;
  logic             neg_q, neg_r;

  logic             sd, sm;
  logic [WIDTH-1:0] mag_d, mag_m;
  logic [WIDTH:0]   m_ext, a_sh, a_next, a_fix;
  logic [WIDTH-1:0] rem_mag;

  assign zero_div = (divisor == '0);

  // Magnitude of the most-negative value wraps to itself, which read as
  // unsigned is the correct magnitude, so no overflow special case exists.
  assign sd    = is_signed & dividend[WIDTH-1];
  assign sm    = is_signed & divisor[WIDTH-1];
  assign mag_d = sd ? (~dividend + ONE) : dividend;
  assign mag_m = sm ? (~divisor + ONE) : divisor;

  assign m_ext   = {1'b0, m_r};
  assign a_sh    = {a_r[WIDTH-1:0], q_r[WIDTH-1]};
  assign a_next  = a_r[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
  assign a_fix   = a_r[WIDTH] ? (a_r + m_ext) : a_r;
  assign rem_mag = a_fix[WIDTH-1:0];

  div_nonrestoring_seq_cu #(.WIDTH(WIDTH)) u_cu (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .zero_div (zero_div),
    .load     (load),
    .iterate  (iterate),
    .correct  (correct),
    .done     (done),
    .busy     (busy),
    .state    (state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r         <= '0;
      q_r         <= '0;
      m_r         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (load) begin
      a_r         <= '0;
      q_r         <= mag_d;
      m_r         <= mag_m;
      neg_q       <= sd ^ sm;
      neg_r       <= sd;
      div_by_zero <= zero_div;
      if (zero_div) begin
        quotient  <= {WIDTH{DBZ_Q_FILL}};
        remainder <= dividend;
      end
    end else if (iterate) begin
      a_r <= a_next;
      q_r <= {q_r[WIDTH-2:0], ~a_next[WIDTH]};
    end else if (correct) begin
      a_r       <= a_fix;
      quotient  <= neg_q ? (~q_r + ONE) : q_r;
      remainder <= neg_r ? (~rem_mag + ONE) : rem_mag;
    end
  end

endmodule

// File: tb/tb_div_nonrestoring_seq.sv
module tb_div_nonrestoring_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance
  logic        start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  dvd8 = '0, dvs8 = '0;
  logic        busy8, done8, dbz8;
  logic [7:0]  quo8, rem8;

  // 16-bit instance
  logic        start16 = 1'b0, sgn16 = 1'b0;
  logic [15:0] dvd16 = '0, dvs16 = '0;
  logic        busy16, done16, dbz16;
  logic [15:0] quo16, rem16;

  div_nonrestoring_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8),
    .dividend(dvd8), .divisor(dvs8), .busy(busy8), .done(done8),
    .quotient(quo8), .remainder(rem8), .div_by_zero(dbz8)
  );

  div_nonrestoring_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .is_signed(sgn16),
    .dividend(dvd16), .divisor(dvs16), .busy(busy16), .done(done16),
    .quotient(quo16), .remainder(rem16), .div_by_zero(dbz16)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];   // {div_by_zero, remainder[15:0], quotient[15:0]}

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division (truncating toward zero, remainder
  // takes the dividend's sign), results reduced modulo 2^w.
  function automatic logic [32:0] model(input bit w16, input bit s,
                                        input logic [15:0] a, input logic [15:0] b);
    int     w;
    longint mask, sa, sb, q, r;
    bit     z;
    w    = w16 ? 16 : 8;
    mask = (longint'(1) << w) - 1;
    sa   = longint'(a) & mask;
    sb   = longint'(b) & mask;
    if (sb == 0) begin
      q = mask;
      r = sa;
      z = 1'b1;
    end else begin
      if (s && sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
      if (s && sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
      q = sa / sb;
      r = sa % sb;
      z = 1'b0;
    end
    return {z, 16'(r & mask), 16'(q & mask)};
  endfunction

  function automatic logic get_done(input bit w16);
    return w16 ? done16 : done8;
  endfunction

  function automatic logic get_busy(input bit w16);
    return w16 ? busy16 : busy8;
  endfunction

  // ---------------- driver ----------------
  task automatic do_op(input bit w16, input bit s, input logic [15:0] a,
                       input logic [15:0] b, input bit pulse_mid, input string tag);
    logic [32:0] e;
    int lat, exp_lat;
    bit seen;
    exp_q.push_back(model(w16, s, a, b));
    exp_lat = ((w16 ? b : {8'h00, b[7:0]}) == 16'h0) ? 1 : (w16 ? 18 : 10);
    @(negedge clk);
    if (w16) begin
      start16 = 1'b1; sgn16 = s; dvd16 = a; dvs16 = b;
    end else begin
      start8 = 1'b1; sgn8 = s; dvd8 = a[7:0]; dvs8 = b[7:0];
    end
    @(posedge clk);
    #1;
    start8 = 1'b0; start16 = 1'b0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({tag, "_busy"}, 64'(get_busy(w16)), 64'd1);
      if (get_done(w16)) seen = 1'b1;
      else if (pulse_mid && lat == 5) begin
        // disturbance: start with other operands while busy
        if (w16) begin start16 = 1'b1; dvd16 = 16'($urandom); dvs16 = 16'h0; end
        else     begin start8  = 1'b1; dvd8  = 8'($urandom);  dvs8  = 8'h0;  end
      end else begin
        start8 = 1'b0; start16 = 1'b0;
      end
    end
    start8 = 1'b0; start16 = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    e = exp_q.pop_front();
    if (w16) begin
      check({tag, "_q"},   64'(quo16), 64'(e[15:0]));
      check({tag, "_r"},   64'(rem16), 64'(e[31:16]));
      check({tag, "_dbz"}, 64'(dbz16), 64'(e[32]));
    end else begin
      check({tag, "_q"},   64'(quo8), 64'(e[7:0]));
      check({tag, "_r"},   64'(rem8), 64'(e[23:16]));
      check({tag, "_dbz"}, 64'(dbz8), 64'(e[32]));
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(get_done(w16)), 64'd0);
    check({tag, "_busy_low"},   64'(get_busy(w16)), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] ra, rb;
    bit rs;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_q",    64'(quo8),  64'd0);
    check("rst_r",    64'(rem8),  64'd0);
    check("rst_dbz",  64'(dbz8),  64'd0);
    rst = 1'b0;

    // directed cases
    do_op(1'b0, 1'b0, 16'd100,  16'd7,   1'b0, "u100_7");
    do_op(1'b0, 1'b1, 16'h009C, 16'd7,   1'b0, "sm100_7");
    do_op(1'b0, 1'b1, 16'd100,  16'h00F9, 1'b0, "s100_m7");
    do_op(1'b0, 1'b0, 16'd37,   16'd0,   1'b0, "u37_0");
    do_op(1'b0, 1'b1, 16'd37,   16'd0,   1'b0, "s37_0");
    do_op(1'b0, 1'b1, 16'h0080, 16'h00FF, 1'b0, "sm128_m1");
    do_op(1'b0, 1'b0, 16'd255,  16'd1,   1'b0, "u255_1");
    do_op(1'b1, 1'b0, 16'd65535, 16'd255, 1'b0, "w16_u65535_255");
    do_op(1'b1, 1'b0, 16'd65535, 16'd255, 1'b1, "w16_pulse");
    do_op(1'b0, 1'b1, 16'h0006, 16'h00FD, 1'b0, "s6_m3");

    // reset during ITER
    @(negedge clk);
    start8 = 1'b1; sgn8 = 1'b0; dvd8 = 8'd200; dvs8 = 8'd3;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy8), 64'd0);
    check("abort_done", 64'(done8), 64'd0);
    check("abort_q",    64'(quo8),  64'd0);
    check("abort_r",    64'(rem8),  64'd0);
    check("abort_dbz",  64'(dbz8),  64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    begin
      bit saw_done;
      saw_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done8) saw_done = 1'b1;
      end
      check("abort_no_done", 64'(saw_done), 64'd0);
    end
    do_op(1'b0, 1'b0, 16'd200, 16'd3, 1'b0, "after_abort");

    // randomized
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 16'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0:       rb = 16'd0;
        1:       rb = 16'h00FF;
        2:       rb = 16'd1;
        default: rb = 16'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 7) == 0) ra = 16'h0080;
      do_op(1'b0, rs, ra, rb, 1'b0, "rand8");
    end
    for (int i = 0; i < 12; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      do_op(1'b1, rs, ra, rb, 1'b0, "rand16");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_nonrestoring_seq.md
# div_nonrestoring_seq

Parametrised sequential non-restoring divider with integrated datapath and control. It supports unsigned and signed (two's-complement) operands selected per operation, and flags divide-by-zero. It retires one quotient bit per clock and sits beside the existing division devices as the general-width, start/done-handshaked divider for datapaths wider than 8 bits.

## Interface
- WIDTH, 8: operand, quotient and remainder width in bits; legal values 2 to 64.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  1 selects two's-complement operation, 0 selects unsigned; captured with start.
- dividend  in  WIDTH  numerator; captured with start.
- divisor  in  WIDTH  denominator; captured with start.
- busy  out  1  high from the accepting edge until the edge that leaves DONE.
- done  out  1  single-cycle pulse marking valid results.
- quotient  out  WIDTH  result; held until the next accepted start.
- remainder  out  WIDTH  result; held until the next accepted start.
- div_by_zero  out  1  divisor was 0; held with the results.

## Operation
- States and transitions:
  - IDLE -> ITER when start=1 and divisor!=0.
  - IDLE -> DONE when start=1 and divisor=0.
  - ITER -> ITER until WIDTH iterations are complete, then ITER -> CORRECT.
  - CORRECT -> DONE.
  - DONE -> IDLE.
- Capture at the accepting edge:
  - magnitudes |dividend| and |divisor| when is_signed=1; raw values otherwise.
  - sign flags neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend), both forced to 0 when is_signed=0.
  - A (WIDTH+1 bits, signed) <= 0; Q <= dividend magnitude; M <= divisor magnitude; iteration counter <= WIDTH-1.
- ITER, one iteration per cycle:
  - Shift {A,Q} left by 1.
  - If the old A was non-negative, A <= A_shifted - M; otherwise A <= A_shifted + M.
  - Q[0] <= ~A_new[WIDTH].
  - Decrement the counter; leave ITER on the cycle the counter is 0.
- CORRECT:
  - If A is negative, A <= A + M.
  - Register quotient = neg_q ? -Q : Q and remainder = neg_r ? -A[WIDTH-1:0] : A[WIDTH-1:0].
- Divide by zero: quotient = all ones, remainder = dividend (raw, unmodified), div_by_zero = 1. No iterations run.
- Signed overflow (most-negative / -1): the magnitude path yields quotient = most-negative and remainder = 0. No special case is needed and div_by_zero stays 0.
- Remainder sign follows the dividend; a zero remainder is reported as 0.
- start while busy=1 is ignored; no queueing.
- div_by_zero clears at the next accepted start.

## Timing
- Accepting edge E is the edge where state=IDLE and start=1.
- Normal operation: ITER occupies edges E+1..E+WIDTH, CORRECT is edge E+WIDTH+1, and done is high for the single cycle after edge E+WIDTH+1. Total latency is WIDTH+2 cycles.
- Divide by zero: done is high in the cycle after edge E (latency 1).
- busy falls at the edge that leaves DONE, so a new start can be accepted one cycle after done.
- quotient, remainder and div_by_zero are valid while done=1 and remain stable until the next accepting edge.
- Reset values: state IDLE, busy 0, done 0, quotient 0, remainder 0, div_by_zero 0.
- Reset asserted mid-operation aborts immediately and asynchronously to the reset values; no done pulse is produced.
- Start may be accepted on the first edge after reset deasserts.

## Structure
- Package div_pkg holds:
  - the state enum typedef (IDLE, ITER, CORRECT, DONE)
  - a localparam function for the counter width, $clog2(WIDTH)
  - the divide-by-zero quotient constant definition.
- The control FSM is a separate sub-module, div_nonrestoring_seq_cu, parametrised by WIDTH.
  - It owns the state and the counter.
  - It emits load, iterate, correct and done strobes.
- The top level holds the A/Q/M registers, the add/subtract unit and the sign handling.

## Test plan
- WIDTH=8, unsigned, 100/7 -> quotient 14, remainder 2, div_by_zero 0; done exactly 10 cycles after the accepting edge.
- WIDTH=8, signed, -100/7 -> quotient 0xF2 (-14), remainder 0xFE (-2); and 100/-7 -> quotient 0xF2, remainder 0x02.
- WIDTH=8, 37/0, both modes -> quotient 0xFF, remainder 0x25, div_by_zero 1; done in the cycle after the accepting edge.
- WIDTH=8, signed, -128/-1 -> quotient 0x80, remainder 0x00, div_by_zero 0. Also unsigned 255/1 -> quotient 255, remainder 0.
- WIDTH=16, unsigned, 65535/255 -> quotient 257, remainder 0. Pulsing start mid-operation is ignored and the result is unchanged.
- Assert rst during ITER -> all outputs 0 immediately and no done pulse. A fresh start after release yields the correct result with full latency.
